// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode / write-back stage.
// Decodes register IDs, reads the 15-entry register file, forwards operands
// from E/M/W, and owns the E pipeline register (with bubble insertion).
// Optional register-file debug port: define DECODE_REG_DEBUG_EN.
module decode_stage #(
  parameter int         NREG   = 15,
  parameter logic [3:0] RSP_ID = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DECODE_REG_DEBUG_EN
  input  logic [3:0]  dbg_addr,
  output logic [63:0] dbg_data,
  output logic [31:0] dbg_wr_cnt,
`endif
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [3:0]  D_stat,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic        E_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_stat,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h8;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register file
  logic [63:0] rf_q [NREG];
  logic [63:0] rf_d [NREG];

  // Decode results
  logic [3:0]  d_dstE;
  logic [3:0]  d_dstM;
  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] d_valA;
  logic [63:0] d_valB;

  // Write enables only for IDs that name a real register
  logic we_e;
  logic we_m;

  // E pipeline register
  logic [3:0]  e_icode_q, e_icode_d;
  logic [3:0]  e_ifun_q,  e_ifun_d;
  logic [3:0]  e_stat_q,  e_stat_d;
  logic [63:0] e_valc_q,  e_valc_d;
  logic [63:0] e_vala_q,  e_vala_d;
  logic [63:0] e_valb_q,  e_valb_d;
  logic [3:0]  e_dste_q,  e_dste_d;
  logic [3:0]  e_dstm_q,  e_dstm_d;
  logic [3:0]  e_srca_q,  e_srca_d;
  logic [3:0]  e_srcb_q,  e_srcb_d;

  // Source and destination register IDs from the instruction class
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA;   d_dstE = D_rB; end
      I_IRMOVQ: begin d_dstE = D_rB; end
      I_RMMOVQ: begin d_srcA = D_rA;   d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB;   d_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA;   d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:   begin d_srcB = RSP_ID; d_dstE = RSP_ID; end
      I_RET:    begin d_srcA = RSP_ID; d_srcB = RSP_ID; d_dstE = RSP_ID; end
      I_PUSHQ:  begin d_srcA = D_rA;   d_srcB = RSP_ID; d_dstE = RSP_ID; end
      I_POPQ:   begin d_srcA = RSP_ID; d_srcB = RSP_ID; d_dstE = RSP_ID; d_dstM = D_rA; end
      default:  ;
    endcase
  end

  // Combinational register file reads; "none" or out-of-range IDs read 0
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (d_srcA != RNONE && int'(d_srcA) < NREG) rd_a = rf_q[d_srcA];
    if (d_srcB != RNONE && int'(d_srcB) < NREG) rd_b = rf_q[d_srcB];
  end

  // Operand A: valP for jumps/call, else nearest in-flight producer wins
  always_comb begin
    d_valA = '0;
    if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
    else if (d_srcA == RNONE)                  d_valA = '0;
    else if (d_srcA == e_dstE)                 d_valA = e_valE;
    else if (d_srcA == M_dstM)                 d_valA = m_valM;
    else if (d_srcA == M_dstE)                 d_valA = M_valE;
    else if (d_srcA == W_dstM)                 d_valA = W_valM;
    else if (d_srcA == W_dstE)                 d_valA = W_valE;
    else                                       d_valA = rd_a;
  end

  // Operand B: same forwarding priority, no valP case
  always_comb begin
    d_valB = '0;
    if (d_srcB == RNONE)        d_valB = '0;
    else if (d_srcB == e_dstE)  d_valB = e_valE;
    else if (d_srcB == M_dstM)  d_valB = m_valM;
    else if (d_srcB == M_dstE)  d_valB = M_valE;
    else if (d_srcB == W_dstM)  d_valB = W_valM;
    else if (d_srcB == W_dstE)  d_valB = W_valE;
    else                        d_valB = rd_b;
  end

  // Register file next state; the M port is applied last so it wins a tie
  always_comb begin
    we_e = (W_dstE != RNONE) && (int'(W_dstE) < NREG);
    we_m = (W_dstM != RNONE) && (int'(W_dstM) < NREG);
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (we_e && W_dstE == 4'(i)) rf_d[i] = W_valE;
      if (we_m && W_dstM == 4'(i)) rf_d[i] = W_valM;
    end
  end

  // Register file storage, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  // E register next state: bubble pattern or decoded fields
  always_comb begin
    e_icode_d = D_icode;
    e_ifun_d  = D_ifun;
    e_stat_d  = D_stat;
    e_valc_d  = D_valC;
    e_vala_d  = d_valA;
    e_valb_d  = d_valB;
    e_dste_d  = d_dstE;
    e_dstm_d  = d_dstM;
    e_srca_d  = d_srcA;
    e_srcb_d  = d_srcB;
    if (E_bubble) begin
      e_icode_d = I_NOP;
      e_ifun_d  = 4'h0;
      e_stat_d  = S_AOK;
      e_valc_d  = '0;
      e_vala_d  = '0;
      e_valb_d  = '0;
      e_dste_d  = RNONE;
      e_dstm_d  = RNONE;
      e_srca_d  = RNONE;
      e_srcb_d  = RNONE;
    end
  end

  // E register flops; reset loads the bubble pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_icode_q <= I_NOP;
      e_ifun_q  <= 4'h0;
      e_stat_q  <= S_AOK;
      e_valc_q  <= '0;
      e_vala_q  <= '0;
      e_valb_q  <= '0;
      e_dste_q  <= RNONE;
      e_dstm_q  <= RNONE;
      e_srca_q  <= RNONE;
      e_srcb_q  <= RNONE;
    end else begin
      e_icode_q <= e_icode_d;
      e_ifun_q  <= e_ifun_d;
      e_stat_q  <= e_stat_d;
      e_valc_q  <= e_valc_d;
      e_vala_q  <= e_vala_d;
      e_valb_q  <= e_valb_d;
      e_dste_q  <= e_dste_d;
      e_dstm_q  <= e_dstm_d;
      e_srca_q  <= e_srca_d;
      e_srcb_q  <= e_srcb_d;
    end
  end

  assign E_icode = e_icode_q;
  assign E_ifun  = e_ifun_q;
  assign E_stat  = e_stat_q;
  assign E_valC  = e_valc_q;
  assign E_valA  = e_vala_q;
  assign E_valB  = e_valb_q;
  assign E_dstE  = e_dste_q;
  assign E_dstM  = e_dstm_q;
  assign E_srcA  = e_srca_q;
  assign E_srcB  = e_srcb_q;

`ifdef DECODE_REG_DEBUG_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Raw register file peek, bypassing forwarding
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != RNONE && int'(dbg_addr) < NREG) dbg_data = rf_q[dbg_addr];
  end

  // Write counter: two ports hitting the same register count once
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (we_e && we_m && W_dstE != W_dstM) wr_cnt_d = wr_cnt_q + 32'd2;
    else if (we_e || we_m)                wr_cnt_d = wr_cnt_q + 32'd1;
  end

  // Write counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_cnt_q <= '0;
    else     wr_cnt_q <= wr_cnt_d;
  end

  assign dbg_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven check of decode_stage plus reset sequences.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [3:0]  M_dstE, M_dstM;
  logic [63:0] M_valE, m_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_stat;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
`ifdef DECODE_REG_DEBUG_EN
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;
  logic [31:0] dbg_wr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
`ifdef DECODE_REG_DEBUG_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_wr_cnt(dbg_wr_cnt),
`endif
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb, stat;
    logic [63:0] valc, valp;
    logic        bubble;
    logic [3:0]  fe_dst;  logic [63:0] fe_val;
    logic [3:0]  fme_dst; logic [63:0] fme_val;
    logic [3:0]  fmm_dst; logic [63:0] fmm_val;
    logic [3:0]  wde;     logic [63:0] wve;
    logic [3:0]  wdm;     logic [63:0] wvm;
    logic [3:0]  x_icode, x_ifun, x_stat;
    logic [63:0] x_valc, x_vala, x_valb;
    logic [3:0]  x_dste, x_dstm, x_srca, x_srcb;
  } vec_t;

  vec_t tbl[$];

  // Vector with no forwarding/writes; expected decode left as "all none"
  function automatic vec_t instr(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb);
    vec_t v;
    v.icode = ic;    v.ifun = 4'h0; v.ra = ra; v.rb = rb; v.stat = 4'h8;
    v.valc = '0;     v.valp = '0;   v.bubble = 1'b0;
    v.fe_dst = 4'hF;  v.fe_val = '0;
    v.fme_dst = 4'hF; v.fme_val = '0;
    v.fmm_dst = 4'hF; v.fmm_val = '0;
    v.wde = 4'hF; v.wve = '0;
    v.wdm = 4'hF; v.wvm = '0;
    v.x_icode = ic;  v.x_ifun = 4'h0; v.x_stat = 4'h8;
    v.x_valc = '0;   v.x_vala = '0;   v.x_valb = '0;
    v.x_dste = 4'hF; v.x_dstm = 4'hF; v.x_srca = 4'hF; v.x_srcb = 4'hF;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    D_icode = v.icode; D_ifun = v.ifun; D_rA = v.ra; D_rB = v.rb; D_stat = v.stat;
    D_valC = v.valc;   D_valP = v.valp; E_bubble = v.bubble;
    e_dstE = v.fe_dst;  e_valE = v.fe_val;
    M_dstE = v.fme_dst; M_valE = v.fme_val;
    M_dstM = v.fmm_dst; m_valM = v.fmm_val;
    W_dstE = v.wde; W_valE = v.wve;
    W_dstM = v.wdm; W_valM = v.wvm;
  endtask

  initial begin
    vec_t v;
`ifdef DECODE_REG_DEBUG_EN
    dbg_addr = 4'hF;
`endif
    drive(instr(4'h6, 4'h1, 4'h2));
    rst = 1'b0;

    // ---- table ----
    v = instr(4'h1, 4'hF, 4'hF); tbl.push_back(v);                                 // 0 nop
    v = instr(4'h1, 4'hF, 4'hF); v.wde = 4'h3; v.wve = 64'h55; tbl.push_back(v);   // 1 write r3
    v = instr(4'h2, 4'h3, 4'h5); v.x_vala = 64'h55; v.x_dste = 4'h5; v.x_srca = 4'h3;
    tbl.push_back(v);                                                              // 2 rrmovq
    v = instr(4'h2, 4'h2, 4'h7); v.fe_dst = 4'h2; v.fe_val = 64'h11;
    v.fme_dst = 4'h2; v.fme_val = 64'h22; v.wde = 4'h2; v.wve = 64'h33;
    v.x_vala = 64'h11; v.x_dste = 4'h7; v.x_srca = 4'h2; tbl.push_back(v);         // 3 e wins
    v.fe_dst = 4'hF; v.x_vala = 64'h22; tbl.push_back(v);                          // 4 M_dstE
    v = instr(4'h2, 4'h2, 4'h7); v.fme_dst = 4'h2; v.fme_val = 64'h22;
    v.fmm_dst = 4'h2; v.fmm_val = 64'h44;
    v.x_vala = 64'h44; v.x_dste = 4'h7; v.x_srca = 4'h2; tbl.push_back(v);         // 5 M_dstM wins
    v = instr(4'h2, 4'h2, 4'h7); v.wde = 4'h2; v.wve = 64'h77; v.wdm = 4'h2; v.wvm = 64'h66;
    v.x_vala = 64'h66; v.x_dste = 4'h7; v.x_srca = 4'h2; tbl.push_back(v);         // 6 W_dstM wins
    v = instr(4'h2, 4'h2, 4'h7); v.x_vala = 64'h66; v.x_dste = 4'h7; v.x_srca = 4'h2;
    tbl.push_back(v);                                                              // 7 rf dual write
    v = instr(4'h1, 4'hF, 4'hF); v.wde = 4'h4; v.wve = 64'hAA; v.wdm = 4'h4; v.wvm = 64'hBB;
    tbl.push_back(v);                                                              // 8 dual write rsp
    v = instr(4'hA, 4'h3, 4'hF); v.x_vala = 64'h55; v.x_valb = 64'hBB;
    v.x_dste = 4'h4; v.x_srca = 4'h3; v.x_srcb = 4'h4; tbl.push_back(v);           // 9 pushq
    v = instr(4'h8, 4'hF, 4'hF); v.valp = 64'h100; v.valc = 64'h300; v.x_valc = 64'h300;
    v.wde = 4'h4; v.wve = 64'h200;
    v.x_vala = 64'h100; v.x_valb = 64'h200; v.x_dste = 4'h4; v.x_srcb = 4'h4;
    tbl.push_back(v);                                                              // 10 call + W fwd
    v = instr(4'h7, 4'hF, 4'hF); v.ifun = 4'h3; v.x_ifun = 4'h3; v.valp = 64'h140;
    v.valc = 64'h500; v.x_valc = 64'h500; v.x_vala = 64'h140; tbl.push_back(v);   // 11 jXX
    v = instr(4'hB, 4'h6, 4'hF); v.fe_dst = 4'h4; v.fe_val = 64'h208;
    v.x_vala = 64'h208; v.x_valb = 64'h208; v.x_dste = 4'h4; v.x_dstm = 4'h6;
    v.x_srca = 4'h4; v.x_srcb = 4'h4; tbl.push_back(v);                            // 12 popq
    v = instr(4'h5, 4'h1, 4'h2); v.valc = 64'h18; v.x_valc = 64'h18;
    v.fe_dst = 4'hF; v.fe_val = 64'hDEAD; v.wde = 4'h2; v.wve = 64'h99;
    v.x_valb = 64'h99; v.x_dstm = 4'h1; v.x_srcb = 4'h2; tbl.push_back(v);         // 13 mrmovq, F no-match
    v = instr(4'h3, 4'hF, 4'h9); v.valc = 64'h1234; v.x_valc = 64'h1234; v.x_dste = 4'h9;
    tbl.push_back(v);                                                              // 14 irmovq
    v = instr(4'h6, 4'h2, 4'h3); v.ifun = 4'h1; v.x_ifun = 4'h1;
    v.x_vala = 64'h99; v.x_valb = 64'h55; v.x_dste = 4'h3; v.x_srca = 4'h2; v.x_srcb = 4'h3;
    tbl.push_back(v);                                                              // 15 OPq
    v = instr(4'h6, 4'h2, 4'h3); v.ifun = 4'h1; v.stat = 4'h4; v.bubble = 1'b1;
    v.x_icode = 4'h1; tbl.push_back(v);                                            // 16 bubble
    v = instr(4'h6, 4'h2, 4'h3); v.ifun = 4'h1; v.x_ifun = 4'h1; v.stat = 4'h1; v.x_stat = 4'h1;
    v.x_vala = 64'h99; v.x_valb = 64'h55; v.x_dste = 4'h3; v.x_srca = 4'h2; v.x_srcb = 4'h3;
    tbl.push_back(v);                                                              // 17 after bubble
    v = instr(4'hD, 4'h1, 4'h2); v.valc = 64'h77; v.x_valc = 64'h77; tbl.push_back(v); // 18 invalid
    v = instr(4'h4, 4'h3, 4'h2); v.valc = 64'h10; v.x_valc = 64'h10;
    v.x_vala = 64'h55; v.x_valb = 64'h99; v.x_srca = 4'h3; v.x_srcb = 4'h2;
    tbl.push_back(v);                                                              // 19 rmmovq
    v = instr(4'h0, 4'hF, 4'hF); v.stat = 4'h4; v.x_stat = 4'h4; tbl.push_back(v); // 20 halt
    v = instr(4'h9, 4'hF, 4'hF); v.x_vala = 64'h200; v.x_valb = 64'h200;
    v.x_dste = 4'h4; v.x_srca = 4'h4; v.x_srcb = 4'h4; tbl.push_back(v);           // 21 ret

    // ---- initial reset: E holds bubble while rst is high ----
    #1 rst = 1'b1;
    #2;
    chk("rst0_icode", 64'(E_icode), 64'h1);
    chk("rst0_dstE",  64'(E_dstE),  64'hF);
    chk("rst0_stat",  64'(E_stat),  64'h8);
    #4 rst = 1'b0;

    // ---- table run: drive, one edge, compare E ----
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v);
      #1;
      if (!v.bubble) begin
        chk("d_srcA", 64'(d_srcA), 64'(v.x_srca));
        chk("d_srcB", 64'(d_srcB), 64'(v.x_srcb));
      end
      @(posedge clk);
      #1;
      chk("E_icode", 64'(E_icode), 64'(v.x_icode));
      chk("E_ifun",  64'(E_ifun),  64'(v.x_ifun));
      chk("E_stat",  64'(E_stat),  64'(v.x_stat));
      chk("E_valC",  E_valC,       v.x_valc);
      chk("E_valA",  E_valA,       v.x_vala);
      chk("E_valB",  E_valB,       v.x_valb);
      chk("E_dstE",  64'(E_dstE),  64'(v.x_dste));
      chk("E_dstM",  64'(E_dstM),  64'(v.x_dstm));
      chk("E_srcA",  64'(E_srcA),  64'(v.x_srca));
      chk("E_srcB",  64'(E_srcB),  64'(v.x_srcb));
      $display("vec %0d icode=%h valA=%h valB=%h dstE=%h dstM=%h srcA=%h srcB=%h stat=%h",
               i, E_icode, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB, E_stat);
    end

    // ---- mid-stream reset pulse between edges ----
    v = instr(4'h4, 4'h3, 4'h2);
    drive(v);
    rst = 1'b1;
    #2;
    chk("rst1_icode", 64'(E_icode), 64'h1);
    chk("rst1_dstE",  64'(E_dstE),  64'hF);
    chk("rst1_stat",  64'(E_stat),  64'h8);
    chk("rst1_valA",  E_valA,       64'h0);
    chk("rst1_srcA",  64'(E_srcA),  64'hF);
    rst = 1'b0;
    #1;
    // First edge after reset loads normally; r3/r2 were cleared
    @(posedge clk);
    #1;
    chk("post_rst_icode", 64'(E_icode), 64'h4);
    chk("post_rst_valA",  E_valA,       64'h0);
    chk("post_rst_valB",  E_valB,       64'h0);
    chk("post_rst_srcA",  64'(E_srcA),  64'h3);
    chk("post_rst_srcB",  64'(E_srcB),  64'h2);
    $display("post-reset icode=%h valA=%h valB=%h", E_icode, E_valA, E_valB);
`ifdef DECODE_REG_DEBUG_EN
    dbg_addr = 4'h4;
    #1;
    chk("dbg_data_r4", dbg_data, 64'h0);
    chk("dbg_wr_cnt",  64'(dbg_wr_cnt), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
